cv32e40x_bitscan_seq: RTL and testbench

Sequential set-bit enumerator, the consumer-side counterpart of the population counter. It accepts a 32-bit word over a valid/ready handshake and emits the index of each set bit, one per beat, LSB first. Each beat carries a running ordinal, so the last beat carries the word's popcount. It is intended for register-list and bitmask iteration, such as push/pop sequencing and mask-driven micro-op expansion.

---
 rtl/cv32e40x_bitscan_seq_pkg.sv | 11 +
 rtl/cv32e40x_bitscan_seq_if.sv | 31 +++
 rtl/cv32e40x_bitscan_seq_ff_one.sv | 21 ++
 rtl/cv32e40x_bitscan_seq.sv | 94 +++++++++
 tb/tb_cv32e40x_bitscan_seq.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/cv32e40x_bitscan_seq_pkg.sv
// Shared types and constants for the set-bit enumerator.
package cv32e40x_pkg;

  localparam int BITSCAN_W = 32;

  typedef enum logic {
    BS_IDLE,
    BS_SCAN
  } bitscan_state_e;

endpackage

// File: rtl/cv32e40x_bitscan_seq_if.sv
// Word-in / index-out handshake bundle for the set-bit enumerator.
interface cv32e40x_bitscan_seq_if
  import cv32e40x_pkg::*;
#(
  parameter int WIDTH = BITSCAN_W,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH) + 1
);

  logic             kill_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [IDX_W-1:0] out_idx_o;
  logic [CNT_W-1:0] out_cnt_o;
  logic             out_last_o;
  logic             out_empty_o;

  modport master (
    output kill_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_idx_o, out_cnt_o, out_last_o, out_empty_o
  );

  modport slave (
    input  kill_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_idx_o, out_cnt_o, out_last_o, out_empty_o
  );

endinterface

// File: rtl/cv32e40x_bitscan_seq_ff_one.sv
// Lowest-set-bit priority encoder.
module cv32e40x_ff_one #(
  parameter int LEN   = 32,
  parameter int IDX_W = $clog2(LEN)
) (
  input  logic [LEN-1:0]   in_i,
  output logic [IDX_W-1:0] first_one_o,
  output logic             no_ones_o
);

  // Scanning downward lets the lowest set bit overwrite any higher match.
  always_comb begin
    first_one_o = '0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (in_i[i]) first_one_o = IDX_W'(i);
    end
  end

  assign no_ones_o = ~|in_i;

endmodule

// File: rtl/cv32e40x_bitscan_seq.sv
// Sequential set-bit enumerator: takes a word, emits one set-bit index per beat, LSB first.
module cv32e40x_bitscan_seq
  import cv32e40x_pkg::*;
#(
  parameter int WIDTH = BITSCAN_W,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic                   clk,
  input logic                   rst,
  cv32e40x_bitscan_seq_if.slave bus
);

  bitscan_state_e   state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] ord_q, ord_d;
  logic             empty_q, empty_d;

  logic [IDX_W-1:0] first_one;
  logic             no_ones;
  logic [WIDTH-1:0] mask_clr;
  logic             scan;
  logic             last;
  logic             consume;
  logic             accept;

  cv32e40x_ff_one #(
    .LEN   (WIDTH),
    .IDX_W (IDX_W)
  ) u_ff_one (
    .in_i        (mask_q),
    .first_one_o (first_one),
    .no_ones_o   (no_ones)
  );

  assign mask_clr = mask_q & (mask_q - WIDTH'(1));
  assign scan     = (state_q == BS_SCAN);
  assign last     = empty_q || (mask_clr == '0);
  assign consume  = scan && bus.out_ready_i && !bus.kill_i;

  assign bus.in_ready_o  = !bus.kill_i && (!scan || (bus.out_ready_i && last));
  assign accept          = bus.in_valid_i && bus.in_ready_o;

  // Beat fields come only from registered state; last is masked so IDLE shows zeros.
  assign bus.out_valid_o = scan;
  assign bus.out_idx_o   = no_ones ? '0 : first_one;
  assign bus.out_cnt_o   = ord_q;
  assign bus.out_last_o  = scan && last;
  assign bus.out_empty_o = empty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BS_IDLE;
      mask_q  <= '0;
      ord_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ord_q   <= ord_d;
      empty_q <= empty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ord_d   = ord_q;
    empty_d = empty_q;
    if (bus.kill_i) begin
      state_d = BS_IDLE;
      mask_d  = '0;
      ord_d   = '0;
      empty_d = 1'b0;
    end else if (accept) begin
      // Covers both a fresh word from IDLE and a reload on the final beat.
      state_d = BS_SCAN;
      mask_d  = bus.in_data_i;
      empty_d = (bus.in_data_i == '0);
      ord_d   = (bus.in_data_i == '0) ? CNT_W'(0) : CNT_W'(1);
    end else if (consume) begin
      if (last) begin
        state_d = BS_IDLE;
        mask_d  = '0;
        ord_d   = '0;
        empty_d = 1'b0;
      end else begin
        mask_d = mask_clr;
        ord_d  = ord_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_bitscan_seq.sv
// Self-checking bench for cv32e40x_bitscan_seq against a beat-queue reference model.
module tb_cv32e40x_bitscan_seq;

  typedef struct {
    int          idx;
    int          cnt;
    bit          last;
    bit          empty;
    logic [31:0] word;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  beat_t q[$];

  cv32e40x_bitscan_seq_if #(.WIDTH(32)) bus ();

  cv32e40x_bitscan_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: expand a word into its full list of beats from the enumeration rules.
  task automatic push_word(input logic [31:0] w);
    beat_t b;
    int    k;
    int    pop;
    pop = $countones(w);
    if (w == 32'h0) begin
      b = '{idx: 0, cnt: 0, last: 1'b1, empty: 1'b1, word: w};
      q.push_back(b);
    end else begin
      k = 0;
      for (int i = 0; i < 32; i++) begin
        if (w[i]) begin
          k++;
          b = '{idx: i, cnt: k, last: (k == pop), empty: 1'b0, word: w};
          q.push_back(b);
        end
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic rdy, input logic k);
    logic exp_valid;
    logic exp_ready;
    @(negedge clk);
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.out_ready_i = rdy;
    bus.kill_i      = k;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = !k && (q.size() == 0 || (rdy && q[0].last));
    chk("out_valid", 32'(bus.out_valid_o), 32'(exp_valid));
    chk("in_ready", 32'(bus.in_ready_o), 32'(exp_ready));
    if (exp_valid) begin
      chk("out_idx", 32'(bus.out_idx_o), 32'(q[0].idx));
      chk("out_cnt", 32'(bus.out_cnt_o), 32'(q[0].cnt));
      chk("out_last", 32'(bus.out_last_o), 32'(q[0].last));
      chk("out_empty", 32'(bus.out_empty_o), 32'(q[0].empty));
      if (q[0].last && !q[0].empty)
        chk("popcnt_on_last", 32'(bus.out_cnt_o), 32'($countones(q[0].word)));
    end
    if (k) q.delete();
    else begin
      if (exp_valid && rdy) void'(q.pop_front());
      if (v && exp_ready) push_word(d);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'h0);
    chk({tag, "_idx"}, 32'(bus.out_idx_o), 32'h0);
    chk({tag, "_cnt"}, 32'(bus.out_cnt_o), 32'h0);
    chk({tag, "_last"}, 32'(bus.out_last_o), 32'h0);
    chk({tag, "_empty"}, 32'(bus.out_empty_o), 32'h0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'h0);
      q.delete();
    end
  endtask

  logic [31:0] w;
  int          sel;

  initial begin
    bus.kill_i      = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_rel");
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'h1);

    // Small word, zero word, all-ones with a stalling consumer.
    cycle(1'b1, 32'h0000_0029, 1'b1, 1'b0);
    drain(10);
    cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    drain(10);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 200 && q.size() != 0; i++)
      cycle(1'b0, 32'h0, (i % 3) == 2, 1'b0);
    drain(10);

    // Back-to-back words with in_valid held high.
    cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0003, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    drain(10);

    // Kill on the second beat, then a fresh single-bit word.
    cycle(1'b1, 32'h0000_F000, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0005, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_0001, 1'b1, 1'b0);
    drain(10);

    // Asynchronous reset in the middle of a scan.
    cycle(1'b1, 32'h0F0F_0F0F, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h0000_0002, 1'b1, 1'b0);
    drain(10);

    // Randomized traffic with stalls and occasional kills.
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       w = 32'h0;
        1:       w = 32'h1 << $urandom_range(0, 31);
        2:       w = $urandom();
        3:       w = $urandom() & $urandom() & $urandom();
        default: w = 32'hFFFF_FFFF;
      endcase
      cycle($urandom_range(0, 2) != 0, w, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
